// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: read ports, issue reservation handshake and two write-back ports.
// master = decode/write-back side, slave = register file.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

interface reg_file_sb_if #(
  parameter int WORD_WIDTH     = `WORD_WIDTH,
  parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH,
  parameter int N_RD           = 2
);
  logic [N_RD*REG_ADDR_WIDTH-1:0] ra;
  logic [N_RD*WORD_WIDTH-1:0]     rd;
  logic [N_RD-1:0]                rd_busy;
  logic                           iss_valid;
  logic [REG_ADDR_WIDTH-1:0]      iss_rd;
  logic                           iss_ready;
  logic                           we0;
  logic [REG_ADDR_WIDTH-1:0]      wa0;
  logic [WORD_WIDTH-1:0]          wd0;
  logic                           we1;
  logic [REG_ADDR_WIDTH-1:0]      wa1;
  logic [WORD_WIDTH-1:0]          wd1;
  logic [REG_ADDR_WIDTH:0]        busy_cnt;

  modport master (
    output ra, iss_valid, iss_rd, we0, wa0, wd0, we1, wa1, wd1,
    input  rd, rd_busy, iss_ready, busy_cnt
  );

  modport slave (
    input  ra, iss_valid, iss_rd, we0, wa0, wd0, we1, wa1, wd1,
    output rd, rd_busy, iss_ready, busy_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// Multi-port integer register file with write-back bypass and a per-register busy scoreboard.
// Optional macro REGFILE_RESET_CLEAR_EN: rst_n also clears the storage (otherwise storage has no reset).
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module reg_file_sb #(
  parameter int WORD_WIDTH     = `WORD_WIDTH,
  parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH,
  parameter int N_RD           = 2
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_sb_if.slave bus
);
  localparam int AW    = REG_ADDR_WIDTH;
  localparam int NREGS = 1 << AW;
  localparam int CW    = AW + 1;

  logic [WORD_WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0]      busy;
  logic [NREGS-1:0]      clr;
  logic [NREGS-1:0]      set;
  logic [NREGS-1:0]      drop;
  logic                  ready;
  logic                  inc;
  logic [1:0]            dec;
  logic [CW-1:0]         busy_cnt_q;
  logic [N_RD*WORD_WIDTH-1:0] rd_c;
  logic [N_RD-1:0]            rd_busy_c;

  // Registers receiving a write-back this cycle; x0 is never tracked.
  always_comb begin
    clr = '0;
    if (bus.we0 && (bus.wa0 != '0)) clr[bus.wa0] = 1'b1;
    if (bus.we1 && (bus.wa1 != '0)) clr[bus.wa1] = 1'b1;
  end

  assign ready = (bus.iss_rd == '0) || !busy[bus.iss_rd] || clr[bus.iss_rd];

  always_comb begin
    set = '0;
    if (bus.iss_valid && ready && (bus.iss_rd != '0)) set[bus.iss_rd] = 1'b1;
  end

  // Set wins over a simultaneous clear, so only unset busy registers can drop.
  assign drop = clr & busy & ~set;
  assign inc  = |(set & ~busy);

  always_comb begin
    dec = '0;
    for (int r = 1; r < NREGS; r++) dec = dec + {1'b0, drop[r]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy       <= set | (busy & ~clr);
      busy_cnt_q <= busy_cnt_q + CW'(inc) - CW'(dec);
    end
  end

`ifdef REGFILE_RESET_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      if (bus.we0 && (bus.wa0 != '0)) regs[bus.wa0] <= bus.wd0;
      if (bus.we1 && (bus.wa1 != '0)) regs[bus.wa1] <= bus.wd1;
    end
  end
`else
  // Storage is left unreset for block-RAM inference; writes are still dropped while in reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (bus.we0 && (bus.wa0 != '0)) regs[bus.wa0] <= bus.wd0;
      if (bus.we1 && (bus.wa1 != '0)) regs[bus.wa1] <= bus.wd1;
    end
  end
`endif

  // Read ports: port 1 write-back is the younger result and wins the bypass.
  always_comb begin
    rd_c      = '0;
    rd_busy_c = '0;
    for (int i = 0; i < N_RD; i++) begin
      logic [AW-1:0] a;
      a = bus.ra[i*AW +: AW];
      if (a == '0)
        rd_c[i*WORD_WIDTH +: WORD_WIDTH] = '0;
      else if (bus.we1 && (bus.wa1 == a))
        rd_c[i*WORD_WIDTH +: WORD_WIDTH] = bus.wd1;
      else if (bus.we0 && (bus.wa0 == a))
        rd_c[i*WORD_WIDTH +: WORD_WIDTH] = bus.wd0;
      else
        rd_c[i*WORD_WIDTH +: WORD_WIDTH] = regs[a];
      rd_busy_c[i] = (a != '0) && busy[a] && !clr[a];
    end
  end

  assign bus.rd        = rd_c;
  assign bus.rd_busy   = rd_busy_c;
  assign bus.iss_ready = ready;
  assign bus.busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomised self-checking bench for reg_file_sb against an array-based reference model.
module tb_reg_file_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  logic [DW-1:0] mregs [32];
  bit            mbusy [32];

  reg_file_sb_if #(.WORD_WIDTH(DW), .REG_ADDR_WIDTH(AW), .N_RD(NR)) bus ();

  reg_file_sb #(.WORD_WIDTH(DW), .REG_ADDR_WIDTH(AW), .N_RD(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic bit m_clr(input logic [AW-1:0] a);
    return (a != 0) && ((bus.we0 && bus.wa0 == a) || (bus.we1 && bus.wa1 == a));
  endfunction

  function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (bus.we1 && bus.wa1 == a) return bus.wd1;
    if (bus.we0 && bus.wa0 == a) return bus.wd0;
    return mregs[a];
  endfunction

  function automatic bit m_rbusy(input logic [AW-1:0] a);
    return (a != 0) && mbusy[a] && !m_clr(a);
  endfunction

  function automatic bit m_ready(input logic [AW-1:0] a);
    return (a == 0) || !mbusy[a] || m_clr(a);
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int r = 1; r < 32; r++) c += int'(mbusy[r]);
    return c;
  endfunction

  task automatic idle();
    bus.ra = '0; bus.iss_valid = 1'b0; bus.iss_rd = '0;
    bus.we0 = 1'b0; bus.wa0 = '0; bus.wd0 = '0;
    bus.we1 = 1'b0; bus.wa1 = '0; bus.wd1 = '0;
  endtask

  // Called after the negedge with inputs applied: check outputs, clock once, advance the model.
  task automatic step();
    logic [AW-1:0] a;
    bit rdy;
    #1;
    for (int i = 0; i < NR; i++) begin
      a = bus.ra[i*AW +: AW];
      chk($sformatf("rd%0d(x%0d)", i, a), bus.rd[i*DW +: DW], m_rd(a));
      chk($sformatf("rd_busy%0d(x%0d)", i, a), {31'b0, bus.rd_busy[i]}, {31'b0, m_rbusy(a)});
    end
    chk($sformatf("iss_ready(x%0d)", bus.iss_rd), {31'b0, bus.iss_ready}, {31'b0, m_ready(bus.iss_rd)});
    chk("busy_cnt", 32'(bus.busy_cnt), 32'(m_cnt()));
    rdy = m_ready(bus.iss_rd);
    @(posedge clk);
    if (bus.we0 && bus.wa0 != 0) begin mregs[bus.wa0] = bus.wd0; mbusy[bus.wa0] = 1'b0; end
    if (bus.we1 && bus.wa1 != 0) begin mregs[bus.wa1] = bus.wd1; mbusy[bus.wa1] = 1'b0; end
    if (bus.iss_valid && rdy && bus.iss_rd != 0) mbusy[bus.iss_rd] = 1'b1;
    @(negedge clk);
  endtask

  task automatic issue(input logic [AW-1:0] r);
    idle(); bus.iss_valid = 1'b1; bus.iss_rd = r; step();
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 31));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    n_chk = 0; n_pass = 0;
    for (int r = 0; r < 32; r++) begin mregs[r] = '0; mbusy[r] = 1'b0; end
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst busy_cnt", 32'(bus.busy_cnt), 32'd0);
    chk("rst rd_busy", {30'b0, bus.rd_busy}, 32'd0);
    chk("rst iss_ready", {31'b0, bus.iss_ready}, 32'd1);
`ifdef REGFILE_RESET_CLEAR_EN
    bus.ra = {5'd9, 5'd5};
    #1;
    chk("rst rd0", bus.rd[DW-1:0], 32'd0);
    chk("rst rd1", bus.rd[2*DW-1:DW], 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Give every register a known value so later reads are defined in either build.
    for (int r = 1; r < 32; r++) begin
      idle(); bus.we0 = 1'b1; bus.wa0 = AW'(r); bus.wd0 = 32'h0101_0101 * r; bus.ra = {AW'(r), AW'(r)};
      step();
    end

    idle(); bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'hDEAD_BEEF; step();
    idle(); bus.ra = {5'd0, 5'd5}; #1; chk("x5 stored", bus.rd[DW-1:0], 32'hDEAD_BEEF); step();

    idle(); bus.we0 = 1'b1; bus.wa0 = 5'd0; bus.wd0 = 32'h1234; bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    #1; chk("x0 iss_ready", {31'b0, bus.iss_ready}, 32'd1); step();
    idle(); #1; chk("x0 rd", bus.rd[DW-1:0], 32'd0); chk("x0 busy_cnt", 32'(bus.busy_cnt), 32'd0); step();

    idle(); bus.we0 = 1'b1; bus.wa0 = 5'd7; bus.wd0 = 32'h11; bus.we1 = 1'b1; bus.wa1 = 5'd7; bus.wd1 = 32'h22;
    bus.ra = {5'd0, 5'd7}; #1; chk("x7 bypass prio", bus.rd[DW-1:0], 32'h22); step();
    idle(); bus.ra = {5'd0, 5'd7}; #1; chk("x7 stored prio", bus.rd[DW-1:0], 32'h22); step();

    issue(5'd3);
    idle(); bus.ra = {5'd0, 5'd3}; bus.iss_rd = 5'd3; #1;
    chk("x3 rd_busy", {31'b0, bus.rd_busy[0]}, 32'd1);
    chk("x3 waw ready", {31'b0, bus.iss_ready}, 32'd0);
    chk("x3 busy_cnt", 32'(bus.busy_cnt), 32'd1);
    step(); step(); step();
    bus.we0 = 1'b1; bus.wa0 = 5'd3; bus.wd0 = 32'h55; #1;
    chk("x3 wb rd", bus.rd[DW-1:0], 32'h55);
    chk("x3 wb rd_busy", {31'b0, bus.rd_busy[0]}, 32'd0);
    step();
    idle(); #1; chk("x3 cleared cnt", 32'(bus.busy_cnt), 32'd0); step();

    issue(5'd4);
    idle(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd4; bus.we0 = 1'b1; bus.wa0 = 5'd4; bus.wd0 = 32'h44; step();
    idle(); bus.ra = {5'd0, 5'd4}; #1;
    chk("x4 set wins", {31'b0, bus.rd_busy[0]}, 32'd1);
    chk("x4 cnt", 32'(bus.busy_cnt), 32'd1);
    step();
    issue(5'd8); issue(5'd9);
    idle(); bus.we0 = 1'b1; bus.wa0 = 5'd8; bus.wd0 = 32'h88; bus.we1 = 1'b1; bus.wa1 = 5'd9; bus.wd1 = 32'h99; step();
    idle(); #1; chk("dual clear cnt", 32'(bus.busy_cnt), 32'd1); step();
    idle(); bus.we1 = 1'b1; bus.wa1 = 5'd4; bus.wd1 = 32'h4444; step();

    issue(5'd10); issue(5'd11); issue(5'd12);
    idle(); bus.ra = {5'd11, 5'd10};
    #2 rst_n = 1'b0;
    #1;
    chk("async rst cnt", 32'(bus.busy_cnt), 32'd0);
    chk("async rst rd_busy", {30'b0, bus.rd_busy}, 32'd0);
    for (int r = 0; r < 32; r++) mbusy[r] = 1'b0;
`ifdef REGFILE_RESET_CLEAR_EN
    for (int r = 0; r < 32; r++) mregs[r] = '0;
`endif
    bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'hBAD; bus.iss_valid = 1'b1; bus.iss_rd = 5'd6;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(); bus.ra = {5'd6, 5'd5}; bus.iss_rd = 5'd6; step();

    for (int n = 0; n < 3000; n++) begin
      bus.ra        = {pick_addr(), pick_addr()};
      bus.iss_valid = 1'($urandom_range(0, 1));
      bus.iss_rd    = pick_addr();
      bus.we0       = ($urandom_range(0, 9) < 4);
      bus.wa0       = pick_addr();
      bus.wd0       = $urandom;
      bus.we1       = ($urandom_range(0, 9) < 4);
      bus.wa1       = ($urandom_range(0, 7) == 0) ? bus.wa0 : pick_addr();
      bus.wd1       = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
